// File: rtl/host_network_interface.sv
// Root-side network interface: host commands become router flits, and per-PE FIN_COMP packets are gathered.
// Optional duplicate-FIN_COMP detection is compiled in when HOST_NI_DUP_CHECK_EN is defined.
`ifndef ROUTER_WIDTH
`define ROUTER_WIDTH 36
`endif
`ifndef ROUTER_INFO_CONFIG
`define ROUTER_INFO_CONFIG 4'h1
`endif
`ifndef ROUTER_INFO_CALC
`define ROUTER_INFO_CALC 4'h2
`endif
`ifndef ROUTER_INFO_FIN_COMP
`define ROUTER_INFO_FIN_COMP 4'h3
`endif
`ifndef ROUTER_FIFO_DEPTH
`define ROUTER_FIFO_DEPTH 4
`endif
`ifndef CREDIT_CNT_WIDTH
`define CREDIT_CNT_WIDTH 3
`endif

module host_network_interface #(
  parameter int         NUM_PE     = 16,
  parameter logic [7:0] BCAST_DEST = 8'hFF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_type,
  input  logic [7:0]               cmd_dest,
  input  logic [5:0]               cmd_addr,
  input  logic [15:0]              cmd_data,
  output logic                     out_data_valid,
  output logic [`ROUTER_WIDTH-1:0] out_data,
  input  logic                     downstream_credit,
  input  logic                     in_data_valid,
  input  logic [`ROUTER_WIDTH-1:0] in_data,
  output logic                     upstream_credit,
  output logic                     busy,
  output logic                     layer_done,
  output logic                     err_dup_fin
);
  localparam int            CW         = `CREDIT_CNT_WIDTH;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(`ROUTER_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2} state_t;

  state_t                   state_r;
  logic [CW-1:0]            credit_r;
  logic [CW-1:0]            credit_next_s;
  logic [NUM_PE-1:0]        done_mask_r;
  logic [NUM_PE-1:0]        mask_set_s;
  logic [NUM_PE-1:0]        mask_next_s;
  logic                     accept_s;
  logic                     send_cmd_s;
  logic                     send_fin_s;
  logic                     send_s;
  logic                     fin_hit_s;
  logic [`ROUTER_WIDTH-1:0] cmd_flit_s;
  logic                     unused_s;

  assign cmd_ready = (state_r == IDLE) && (credit_r != CW'(0));
  assign busy      = (state_r != IDLE);
  assign unused_s  = ^in_data[31:8];

  // Command decode, credit arithmetic and completion-mask update.
  always_comb begin
    accept_s   = cmd_valid && cmd_ready;
    send_cmd_s = accept_s && (cmd_type != 2'b11);
    send_fin_s = (state_r == FIN) && (credit_r != CW'(0));
    send_s     = send_cmd_s || send_fin_s;
    case (cmd_type)
      2'b00:   cmd_flit_s = {`ROUTER_INFO_CONFIG, cmd_dest, 4'h0, cmd_addr[3:0], cmd_data};
      2'b01:   cmd_flit_s = {`ROUTER_INFO_CONFIG, cmd_dest, 1'b1, cmd_addr, 1'b0, cmd_data};
      2'b10:   cmd_flit_s = {`ROUTER_INFO_CALC, BCAST_DEST, 8'h00, 16'h0000};
      default: cmd_flit_s = {`ROUTER_WIDTH{1'b0}};
    endcase
    // A send and a returned credit in the same cycle cancel; the count saturates at the FIFO depth.
    if (send_s && !downstream_credit) begin
      credit_next_s = credit_r - CW'(1);
    end else if (!send_s && downstream_credit && (credit_r != CREDIT_MAX)) begin
      credit_next_s = credit_r + CW'(1);
    end else begin
      credit_next_s = credit_r;
    end
    fin_hit_s  = in_data_valid && (in_data[`ROUTER_WIDTH-1:32] == `ROUTER_INFO_FIN_COMP) && (state_r == RUN);
    mask_set_s = {NUM_PE{1'b0}};
    for (int i = 0; i < NUM_PE; i++) begin
      mask_set_s[i] = fin_hit_s && (in_data[7:0] == 8'(i));
    end
    mask_next_s = done_mask_r | mask_set_s;
  end

  // Registered FSM, credit counter and every output flit/strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      credit_r        <= CREDIT_MAX;
      done_mask_r     <= {NUM_PE{1'b0}};
      out_data_valid  <= 1'b0;
      out_data        <= {`ROUTER_WIDTH{1'b0}};
      upstream_credit <= 1'b0;
      layer_done      <= 1'b0;
`ifdef HOST_NI_DUP_CHECK_EN
      err_dup_fin     <= 1'b0;
`endif
    end else begin
      credit_r        <= credit_next_s;
      upstream_credit <= in_data_valid;
      out_data_valid  <= send_s;
      layer_done      <= send_fin_s;
      case (state_r)
        IDLE: begin
          if (send_cmd_s) out_data <= cmd_flit_s;
          if (accept_s && (cmd_type == 2'b10)) state_r <= RUN;
        end
        RUN: begin
          done_mask_r <= mask_next_s;
          if (&mask_next_s) state_r <= FIN;
`ifdef HOST_NI_DUP_CHECK_EN
          if (|(mask_set_s & done_mask_r)) begin
            err_dup_fin <= 1'b1;
`ifndef SYNTHESIS
            $display("host_network_interface: duplicate FIN_COMP from PE %0d", in_data[7:0]);
`endif
          end
`endif
        end
        FIN: begin
          if (send_fin_s) begin
            out_data    <= {`ROUTER_INFO_FIN_COMP, BCAST_DEST, 8'h00, 16'h0000};
            done_mask_r <= {NUM_PE{1'b0}};
            state_r     <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef HOST_NI_DUP_CHECK_EN
  assign err_dup_fin = 1'b0;
`endif

endmodule

// File: doc/host_network_interface.md
Name: host_network_interface

Overview:
- Root-side endpoint of the quadtree packet protocol; the initiator for the per-PE network interfaces.
- Converts host commands into 36-bit router flits: PE status config, input-activation config and start-calculation.
- Injects flits into the root router under credit flow control and sinks FIN_COMP packets returned by every PE.
- When all PEs report FIN_COMP, broadcasts a FIN_COMP packet back to all PEs (their layer_done) and pulses layer_done to the host.

Parameters:
- NUM_PE, 16, number of PEs; bit width of the completion mask (1..256).
- BCAST_DEST, 8'hFF, destination field value meaning all PEs.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_type  in  2  00 PE status write, 01 act write, 10 start calc, 11 reserved
- cmd_dest  in  8  destination PE index, or BCAST_DEST
- cmd_addr  in  6  register index [3:0] for type 00; act index [5:0] for type 01
- cmd_data  in  16  payload
- out_data_valid  out  1  flit valid to root router
- out_data  out  `ROUTER_WIDTH  flit: [35:32] info, [31:16] addr, [15:0] data
- downstream_credit  in  1  one-cycle credit return from root router
- in_data_valid  in  1  flit valid from root router
- in_data  in  `ROUTER_WIDTH  incoming flit
- upstream_credit  out  1  credit return to root router
- busy  out  1  high while state is not IDLE
- layer_done  out  1  one-cycle pulse when FIN_COMP broadcast is issued
- err_dup_fin  out  1  sticky duplicate-FIN_COMP flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high.
- Reset values:
  - out_data_valid=0, out_data=0, upstream_credit=0, layer_done=0, err_dup_fin=0.
  - credit_count=`ROUTER_FIFO_DEPTH, done_mask=0, state=IDLE.
  - Reset mid-operation aborts any pending send and clears the mask; no flit is emitted on the cycle after reset.
- Flit address format: addr[15:8]=destination, addr[7:0]=local field.
  - Type 00: local = {1'b0, 3'b000, cmd_addr[3:0]}, info=`ROUTER_INFO_CONFIG.
  - Type 01: local = {1'b1, cmd_addr[5:0], 1'b0}, info=`ROUTER_INFO_CONFIG.
  - Type 10: addr = {BCAST_DEST, 8'h00}, data=0, info=`ROUTER_INFO_CALC; cmd_dest is ignored.
  - Type 11: accepted and dropped; no flit is sent and credit is not consumed.
- Credit counter (`CREDIT_CNT_WIDTH bits):
  - -1 on each flit sent; +1 on downstream_credit.
  - Send and credit return in the same cycle leaves the count unchanged.
  - Never sends at 0; never exceeds `ROUTER_FIFO_DEPTH.
- FSM IDLE:
  - cmd_ready = (credit_count>0).
  - On accept, the flit appears registered on out_data with out_data_valid=1 the next cycle; out_data_valid is a single-cycle pulse per flit.
  - Back-to-back accepts are allowed every cycle while credit remains.
  - Accepted type 10 goes to RUN.
- FSM RUN:
  - cmd_ready=0.
  - Each incoming flit with info `ROUTER_INFO_FIN_COMP sets done_mask[in_data[7:0]]; an index >= NUM_PE is ignored.
  - Other incoming info types are discarded.
  - When done_mask is all ones (including an update landing this cycle), go to FIN.
- FSM FIN:
  - When credit_count>0, send {`ROUTER_INFO_FIN_COMP, BCAST_DEST, 8'h00, 16'h0000}.
  - Pulse layer_done in the same cycle out_data_valid rises.
  - Clear done_mask and return to IDLE.
  - If credit is 0, hold in FIN until credit returns.
- Incoming flits in any state:
  - Every in_data_valid produces upstream_credit=1 exactly one cycle later.
  - in_data_valid is never back-pressured.
  - Incoming flits in IDLE/FIN are counted for credit only and do not update the mask.
- busy = (state!=IDLE).

Optional Feature:
- Macro: HOST_NI_DUP_CHECK_EN.
- When defined:
  - A FIN_COMP for an index whose mask bit is already set in RUN sets err_dup_fin (sticky until rst).
  - The mask is unchanged and the flit's credit is still returned.
  - A simulation-only $display reports the PE index.
- When undefined: err_dup_fin is tied to 0 and duplicates are silently ignored.

Test Plan:
- Reset, then type 00 cmd dest=3 addr=5 data=16'h00AB -> next cycle out_data=36'h1_0305_00AB with CONFIG info in [35:32]; credit_count = depth-1.
- Type 01 dest=BCAST addr=6'd9 data=16'h1234 -> out_data addr field 16'hFF92, data 16'h1234, info CONFIG.
- Send `ROUTER_FIFO_DEPTH commands with no downstream_credit -> cmd_ready drops after the last one; one downstream_credit pulse -> exactly one further command accepted.
- Type 10, then FIN_COMP from PEs 0..15 in scrambled order with one pair arriving on consecutive cycles -> upstream_credit pulses 16 times, each one cycle after input; FIN_COMP broadcast flit plus layer_done pulse; state returns to IDLE.
- RUN with FIN_COMP from PE 2 twice (HOST_NI_DUP_CHECK_EN defined) -> err_dup_fin=1 and stays high; completion still requires all 16 distinct PEs.
- Assert rst for 1 cycle in RUN with done_mask=16'h00FF -> mask=0, state IDLE, credit_count=depth, out_data_valid=0 the following cycle.
